// File: rtl/led_pwm.sv
// ---------------------------------------------------------------------------
// led_pwm
//   Eight-channel LED PWM dimmer on the iomem bus. Each channel has an 8-bit
//   duty value. Writes land in a pending bank that is copied into the active
//   bank only when the PWM counter wraps. This keeps every output period
//   built from a single duty value, with no glitches when the duty changes.
//   The gpio leds drive the per-channel enables. These enables and CTRL are
//   not buffered and act on the next clock.
//
// Parameters
//   ADDR      block select, compared with iomem_addr[31:16]
//   PRESCALE  clocks per PWM count step (>= 1)
//
// Ports
//   ck           system clock
//   resetn       synchronous, active-low reset
//   iomem_valid  bus request
//   iomem_ready  one-cycle acknowledge, one cycle after the request is taken
//   iomem_wstrb  byte write strobes (0 = read)
//   iomem_addr   byte address: [31:16] block select, [4:2] register index
//   iomem_wdata  write data
//   iomem_rdata  read data (value before any write), valid while iomem_ready
//   enable       per-channel enable (gpio leds)
//   pwm_out      registered PWM outputs
//   period_tick  one-cycle pulse after each PWM period wrap
//
// Register map (index = iomem_addr[4:2])
//   0 DUTY_LO  R/W  bytes 0..3 = pending duty ch0..ch3
//   1 DUTY_HI  R/W  bytes 0..3 = pending duty ch4..ch7
//   2 CTRL     R/W  bit0 global enable, bit1 invert
//   3 STATUS   RO   [7:0] current counter
//   4..7       read 0, writes ignored
// ---------------------------------------------------------------------------
module led_pwm #(
    parameter logic [15:0] ADDR     = 16'h0400,
    parameter int unsigned PRESCALE = 16
) (
    input  logic        ck,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic [7:0]  enable,
    output logic [7:0]  pwm_out,
    output logic        period_tick
);

    // A prescaler of 1 still needs a 1-bit register. That register stays at 0,
    // so step is asserted on every clock.
    localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [2:0] IDX_DUTY_LO = 3'd0;
    localparam logic [2:0] IDX_DUTY_HI = 3'd1;
    localparam logic [2:0] IDX_CTRL    = 3'd2;
    localparam logic [2:0] IDX_STATUS  = 3'd3;

    logic [PW-1:0] presc;
    logic          step;
    logic [7:0]    cnt;
    logic          wrap;

    logic [7:0]    pending [8];
    logic [7:0]    active  [8];
    logic          ctrl_en;
    logic          ctrl_inv;

    logic          sel;
    logic [2:0]    idx;
    logic [31:0]   rd_mux;

    // Only the block select and the register index are decoded.
    logic          unused_addr;
    assign unused_addr = ^{iomem_addr[15:5], iomem_addr[1:0]};

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    assign step = (presc == PRESC_LAST);
    assign wrap = step && (cnt == 8'hFF);

    always_ff @(posedge ck) begin
        if (!resetn) begin
            presc       <= '0;
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            presc       <= step ? '0 : presc + 1'b1;
            if (step)
                cnt <= cnt + 8'd1;
            period_tick <= wrap;
        end
    end

    // ------------------------------------------------------------------
    // Bus interface
    // ------------------------------------------------------------------
    // The !iomem_ready term stops one request from being taken twice.
    // Because of it, a request whose valid stays high is acknowledged on
    // every second cycle.
    assign sel = iomem_valid && !iomem_ready && (iomem_addr[31:16] == ADDR);
    assign idx = iomem_addr[4:2];

    always_comb begin
        rd_mux = '0;
        case (idx)
            IDX_DUTY_LO: rd_mux = {pending[3], pending[2], pending[1], pending[0]};
            IDX_DUTY_HI: rd_mux = {pending[7], pending[6], pending[5], pending[4]};
            IDX_CTRL:    rd_mux = {30'd0, ctrl_inv, ctrl_en};
            IDX_STATUS:  rd_mux = {24'd0, cnt};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            ctrl_en     <= 1'b0;
            ctrl_inv    <= 1'b0;
            for (int unsigned i = 0; i < 8; i++)
                pending[i] <= '0;
        end else begin
            iomem_ready <= sel;
            // rd_mux is sampled in the same cycle as the write, so a write
            // returns the value the register held before it.
            iomem_rdata <= sel ? rd_mux : '0;
            if (sel) begin
                case (idx)
                    IDX_DUTY_LO: begin
                        for (int unsigned b = 0; b < 4; b++)
                            if (iomem_wstrb[b])
                                pending[b] <= iomem_wdata[8*b +: 8];
                    end
                    IDX_DUTY_HI: begin
                        for (int unsigned b = 0; b < 4; b++)
                            if (iomem_wstrb[b])
                                pending[4+b] <= iomem_wdata[8*b +: 8];
                    end
                    IDX_CTRL: begin
                        if (iomem_wstrb[0]) begin
                            ctrl_en  <= iomem_wdata[0];
                            ctrl_inv <= iomem_wdata[1];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow load and PWM compare
    // ------------------------------------------------------------------
    // active is copied from the value pending holds before this clock edge.
    // A bus write that lands on the wrap edge therefore waits for the next
    // wrap.
    always_ff @(posedge ck) begin
        if (!resetn) begin
            pwm_out <= '0;
            for (int unsigned i = 0; i < 8; i++)
                active[i] <= '0;
        end else begin
            if (wrap) begin
                for (int unsigned i = 0; i < 8; i++)
                    active[i] <= pending[i];
            end
            for (int unsigned i = 0; i < 8; i++)
                pwm_out[i] <= (ctrl_en & enable[i] & (cnt < active[i])) ^ ctrl_inv;
        end
    end

endmodule

// File: tb/tb_led_pwm.sv
`timescale 1ns/1ps
module tb_led_pwm;

    localparam logic [15:0] ADDR = 16'h0400;

    logic        ck = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = '0;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [31:0] iomem_rdata;
    logic [7:0]  enable = '0;
    logic [7:0]  pwm_out;
    logic        period_tick;

    always #5 ck = ~ck;

    led_pwm #(.ADDR(ADDR), .PRESCALE(1)) dut (
        .ck          (ck),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .enable      (enable),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model. The registers are those the software can see. With
    // PRESCALE=1 the counter value is the number of clock edges since reset
    // was released, taken mod 256.
    logic [7:0]  m_pend [8];
    logic        m_en  = 1'b0;
    logic        m_inv = 1'b0;
    int unsigned cyc   = 0;
    int          hi [8];

    always @(posedge ck) cyc <= resetn ? cyc + 1 : 0;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 8'h00;
        m_en  = 1'b0;
        m_inv = 1'b0;
    endtask

    function automatic logic [31:0] exp_reg(logic [2:0] idx);
        case (idx)
            3'd0:    return {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
            3'd1:    return {m_pend[7], m_pend[6], m_pend[5], m_pend[4]};
            3'd2:    return {30'd0, m_inv, m_en};
            default: return 32'd0;
        endcase
    endfunction

    // Number of high cycles expected in one full period.
    function automatic int exp_hi(int ch, logic [7:0] duty);
        int base;
        base = (m_en && enable[ch]) ? int'(duty) : 0;
        return m_inv ? 256 - base : base;
    endfunction

    task automatic bus(input logic [2:0] idx, input logic [3:0] wstrb,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        iomem_addr  = {ADDR, 11'h000, idx, 2'b00};
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        iomem_valid = 1'b1;
        for (int k = 1; k <= 8 && !got; k++) begin
            tick();
            if (iomem_ready) begin
                got = 1'b1;
                lat = k;
            end
        end
        rdata       = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_ack idx=%0d: iomem_ready never rose within 8 cycles", idx);
        end else if (wstrb != 4'h0) begin
            case (idx)
                3'd0: for (int b = 0; b < 4; b++) if (wstrb[b]) m_pend[b]   = wdata[8*b +: 8];
                3'd1: for (int b = 0; b < 4; b++) if (wstrb[b]) m_pend[4+b] = wdata[8*b +: 8];
                3'd2: if (wstrb[0]) begin m_en = wdata[0]; m_inv = wdata[1]; end
                default: ;
            endcase
        end
    endtask

    // Finds a period_tick. When skip is set, the tick currently showing is
    // ignored. The task then counts high samples per channel over the 256
    // cycles that follow the tick.
    task automatic measure(input bit skip);
        bit found;
        found = 1'b0;
        if (skip) tick();
        for (int k = 0; k < 600 && !found; k++) begin
            if (period_tick) found = 1'b1;
            else tick();
        end
        for (int i = 0; i < 8; i++) hi[i] = 0;
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL period_tick_wait: no period_tick within 600 cycles");
        end else begin
            for (int s = 0; s < 256; s++) begin
                tick();
                for (int ch = 0; ch < 8; ch++) hi[ch] += int'(pwm_out[ch]);
            end
        end
    endtask

    task automatic wait_cnt(input int unsigned c);
        for (int k = 0; k < 600 && (cyc % 256) != c; k++) tick();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        resetn = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({iomem_ready, period_tick, pwm_out} !== 10'd0 || iomem_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b tick=%b pwm=%h rdata=%h, required all 0",
                     iomem_ready, period_tick, pwm_out, iomem_rdata);
        end
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            bus(3'(i), 4'h0, 32'h0, rd, lat);
            n_tests++;
            if (rd !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_read idx%0d: got %h required 00000000", i, rd);
            end
            n_tests++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL reset_ack_latency idx%0d: got %0d required 1", i, lat);
            end
            tick();
            n_tests++;
            if (iomem_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ack_width idx%0d: ready=%b required 0", i, iomem_ready);
            end
            n_tests++;
            if (pwm_out !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_pwm: pwm=%h required 00", pwm_out);
            end
        end
    endtask

    task automatic test_tick_status();
        logic [31:0] rd;
        int lat;
        for (int k = 0; k < 300; k++) begin
            tick();
            n_tests++;
            if (period_tick !== ((cyc % 256) == 0 && cyc != 0)) begin
                n_fail++;
                $display("FAIL period_tick cyc=%0d: got %b", cyc, period_tick);
            end
        end
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 90)) tick();
            bus(3'd3, 4'h0, 32'h0, rd, lat);
            n_tests++;
            if (rd !== 32'((cyc - 1) % 256)) begin
                n_fail++;
                $display("FAIL status_read: got %h required %h", rd, 32'((cyc - 1) % 256));
            end
        end
    endtask

    task automatic test_basic_duty();
        logic [31:0] rd;
        int lat;
        enable = 8'hFF;
        bus(3'd2, 4'hF, 32'h1, rd, lat);
        bus(3'd0, 4'hF, 32'h00FF8040, rd, lat);
        measure(1'b1);
        for (int ch = 0; ch < 8; ch++) begin
            n_tests++;
            if (hi[ch] !== exp_hi(ch, m_pend[ch])) begin
                n_fail++;
                $display("FAIL basic_duty ch%0d: high=%0d required %0d", ch, hi[ch], exp_hi(ch, m_pend[ch]));
            end
        end
    endtask

    task automatic test_mid_period();
        logic [31:0] rd;
        int lat, old, c0, cnt_hi, exp_part;
        bit seen;
        old = int'(m_pend[0]);
        wait_cnt(100);
        bus(3'd0, 4'h1, 32'h00000080, rd, lat);
        bus(3'd0, 4'h0, 32'h0, rd, lat);
        n_tests++;
        if (rd !== exp_reg(3'd0)) begin
            n_fail++;
            $display("FAIL mid_readback: got %h required %h", rd, exp_reg(3'd0));
        end
        c0 = int'(cyc % 256);
        exp_part = (c0 < old) ? old - c0 : 0;
        cnt_hi = 0;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            tick();
            cnt_hi += int'(pwm_out[0]);
            seen = period_tick;
        end
        n_tests++;
        if (cnt_hi !== exp_part || !seen) begin
            n_fail++;
            $display("FAIL mid_old_duty: high=%0d required %0d (tick seen=%b)", cnt_hi, exp_part, seen);
        end
        measure(1'b0);
        n_tests++;
        if (hi[0] !== exp_hi(0, m_pend[0])) begin
            n_fail++;
            $display("FAIL mid_new_duty: high=%0d required %0d", hi[0], exp_hi(0, m_pend[0]));
        end
    endtask

    task automatic test_coincident();
        logic [31:0] rd;
        logic [7:0] old;
        int lat;
        old = m_pend[0];
        wait_cnt(255);
        bus(3'd0, 4'h1, 32'h00000020, rd, lat);
        n_tests++;
        if (period_tick !== 1'b1 || lat !== 1) begin
            n_fail++;
            $display("FAIL coincident_setup: tick=%b lat=%0d required 1/1", period_tick, lat);
        end
        measure(1'b0);
        n_tests++;
        if (hi[0] !== exp_hi(0, old)) begin
            n_fail++;
            $display("FAIL coincident_old: high=%0d required %0d", hi[0], exp_hi(0, old));
        end
        measure(1'b0);
        n_tests++;
        if (hi[0] !== exp_hi(0, m_pend[0])) begin
            n_fail++;
            $display("FAIL coincident_new: high=%0d required %0d", hi[0], exp_hi(0, m_pend[0]));
        end
    endtask

    task automatic test_invert();
        logic [31:0] rd;
        int lat;
        enable = 8'h0F;
        bus(3'd0, 4'hF, 32'h40404040, rd, lat);
        bus(3'd1, 4'hF, 32'h40404040, rd, lat);
        bus(3'd2, 4'h1, 32'h3, rd, lat);
        measure(1'b1);
        for (int ch = 0; ch < 8; ch++) begin
            n_tests++;
            if (hi[ch] !== exp_hi(ch, m_pend[ch])) begin
                n_fail++;
                $display("FAIL invert ch%0d: high=%0d required %0d", ch, hi[ch], exp_hi(ch, m_pend[ch]));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd;
        int lat;
        for (int r = 0; r < 6; r++) begin
            enable = 8'($urandom);
            wd = (r == 0) ? 32'h01FE00FF : $urandom;
            bus(3'd0, (r == 0) ? 4'hF : 4'($urandom), wd, rd, lat);
            wd = (r == 0) ? 32'hFF00FE01 : $urandom;
            bus(3'd1, (r == 0) ? 4'hF : 4'($urandom), wd, rd, lat);
            bus(3'd2, 4'h1, {30'd0, 1'($urandom), (r == 0) ? 1'b1 : 1'($urandom)}, rd, lat);
            for (int i = 0; i < 3; i++) begin
                bus(3'(i), 4'h0, 32'h0, rd, lat);
                n_tests++;
                if (rd !== exp_reg(3'(i))) begin
                    n_fail++;
                    $display("FAIL random_readback r%0d idx%0d: got %h required %h", r, i, rd, exp_reg(3'(i)));
                end
            end
            measure(1'b1);
            for (int ch = 0; ch < 8; ch++) begin
                n_tests++;
                if (hi[ch] !== exp_hi(ch, m_pend[ch])) begin
                    n_fail++;
                    $display("FAIL random_duty r%0d ch%0d: high=%0d required %0d", r, ch, hi[ch], exp_hi(ch, m_pend[ch]));
                end
            end
        end
    endtask

    task automatic test_strobe_ignore();
        logic [31:0] rd, pre;
        int lat;
        enable = 8'hFF;
        bus(3'd2, 4'hF, 32'h1, rd, lat);
        bus(3'd1, 4'hF, 32'h44332211, rd, lat);
        pre = exp_reg(3'd1);
        bus(3'd1, 4'b0010, 32'hAABBCCDD, rd, lat);
        n_tests++;
        if (rd !== pre) begin
            n_fail++;
            $display("FAIL strobe_prewrite_rdata: got %h required %h", rd, pre);
        end
        bus(3'd3, 4'hF, 32'hFFFFFFFF, rd, lat);
        bus(3'd5, 4'hF, 32'hFFFFFFFF, rd, lat);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL idx5_read: got %h required 00000000", rd);
        end
        for (int i = 0; i < 3; i++) begin
            bus(3'(i), 4'h0, 32'h0, rd, lat);
            n_tests++;
            if (rd !== exp_reg(3'(i))) begin
                n_fail++;
                $display("FAIL strobe_readback idx%0d: got %h required %h", i, rd, exp_reg(3'(i)));
            end
        end
        measure(1'b1);
        for (int ch = 4; ch < 8; ch++) begin
            n_tests++;
            if (hi[ch] !== exp_hi(ch, m_pend[ch])) begin
                n_fail++;
                $display("FAIL strobe_duty ch%0d: high=%0d required %0d", ch, hi[ch], exp_hi(ch, m_pend[ch]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        iomem_addr  = {ADDR, 11'h000, 3'd2, 2'b00};
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++;
            if (iomem_ready !== (k % 2 == 0) ||
                (iomem_ready && iomem_rdata !== exp_reg(3'd2))) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d: ready=%b rdata=%h", k, iomem_ready, iomem_rdata);
            end
        end
        iomem_valid = 1'b0;
        tick();
        // A request to another block must be ignored.
        iomem_addr  = {ADDR + 16'd1, 11'h000, 3'd2, 2'b00};
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h0;
        iomem_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (iomem_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL decode_other_block k=%0d: ready=%b required 0", k, iomem_ready);
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        bus(3'd2, 4'h0, 32'h0, rd, lat);
        n_tests++;
        if (rd !== exp_reg(3'd2)) begin
            n_fail++;
            $display("FAIL decode_ctrl_kept: got %h required %h", rd, exp_reg(3'd2));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        enable = 8'hFF;
        bus(3'd2, 4'h1, 32'h3, rd, lat);
        wait_cnt(80);
        resetn = 1'b0;
        tick();
        n_tests++;
        if ({iomem_ready, period_tick, pwm_out} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: ready=%b tick=%b pwm=%h required 0",
                     iomem_ready, period_tick, pwm_out);
        end
        tick();
        resetn = 1'b1;
        model_reset();
        bus(3'd3, 4'h0, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_status: got %h required 00000000", rd);
        end
        for (int i = 0; i < 3; i++) begin
            bus(3'(i), 4'h0, 32'h0, rd, lat);
            n_tests++;
            if (rd !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_mid_reg idx%0d: got %h required 0", i, rd);
            end
        end
        bus(3'd2, 4'h1, 32'h2, rd, lat);
        measure(1'b1);
        for (int ch = 0; ch < 8; ch++) begin
            n_tests++;
            if (hi[ch] !== exp_hi(ch, m_pend[ch])) begin
                n_fail++;
                $display("FAIL reset_mid_duty ch%0d: high=%0d required %0d", ch, hi[ch], exp_hi(ch, m_pend[ch]));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tick_status();
        test_basic_duty();
        test_mid_period();
        test_coincident();
        test_invert();
        test_random();
        test_strobe_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
